// File: rtl/priv_trap_pkg.sv
// priv_trap_pkg
// Shared types and constants for the machine-mode trap sequencer.
//   trap_state_t : sequencer FSM states
//   exc_code_t   : synchronous exception cause codes
//   int_code_t   : interrupt cause codes
//   trap_cause_t : {intr, code} pair carried through the sequencer
//   EXC_BIT_*    : bit positions inside exc_flags (bit 11 = breakpoint ... bit 0 = fault_l)
//   INT_BIT_*    : bit positions inside int_pend  (bit 2 = ext, 1 = soft, 0 = timer)
package priv_trap_pkg;

    localparam int CODE_W = 5;
    localparam int EXC_W  = 12;
    localparam int INT_W  = 3;

    // exc_flags layout: MSB-first matches exception priority, highest first.
    localparam int EXC_BIT_FAULT_L          = 0;
    localparam int EXC_BIT_FAULT_S          = 1;
    localparam int EXC_BIT_FAULT_LOAD_PAGE  = 2;
    localparam int EXC_BIT_FAULT_STORE_PAGE = 3;
    localparam int EXC_BIT_MAL_L            = 4;
    localparam int EXC_BIT_MAL_S            = 5;
    localparam int EXC_BIT_ENV              = 6;
    localparam int EXC_BIT_MAL_INSN         = 7;
    localparam int EXC_BIT_ILLEGAL_INSN     = 8;
    localparam int EXC_BIT_FAULT_INSN       = 9;
    localparam int EXC_BIT_FAULT_INSN_PAGE  = 10;
    localparam int EXC_BIT_BREAKPOINT       = 11;

    localparam int INT_BIT_TIMER = 0;
    localparam int INT_BIT_SOFT  = 1;
    localparam int INT_BIT_EXT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_UPDATE   = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_SLEEP    = 3'd4
    } trap_state_t;

    typedef enum logic [CODE_W-1:0] {
        EXC_MAL_INSN    = 5'd0,
        EXC_FAULT_INSN  = 5'd1,
        EXC_ILLEGAL     = 5'd2,
        EXC_BREAKPOINT  = 5'd3,
        EXC_MAL_LOAD    = 5'd4,
        EXC_FAULT_LOAD  = 5'd5,
        EXC_MAL_STORE   = 5'd6,
        EXC_FAULT_STORE = 5'd7,
        EXC_ECALL_U     = 5'd8,
        EXC_ECALL_S     = 5'd9,
        EXC_ECALL_M     = 5'd11,
        EXC_PAGE_INSN   = 5'd12,
        EXC_PAGE_LOAD   = 5'd13,
        EXC_PAGE_STORE  = 5'd15
    } exc_code_t;

    typedef enum logic [CODE_W-1:0] {
        INT_SOFT  = 5'd3,
        INT_TIMER = 5'd7,
        INT_EXT   = 5'd11
    } int_code_t;

    typedef struct packed {
        logic              intr;
        logic [CODE_W-1:0] code;
    } trap_cause_t;

endpackage

// File: rtl/priv_trap_prio_enc.sv
// priv_trap_prio_enc
// Combinational priority encoder: picks one trap cause from the raw flags.
//   exc_flags : synchronous exception flags (layout in priv_trap_pkg)
//   int_pend  : masked pending interrupts {ext, soft, timer}
//   curr_priv : current privilege, selects the ecall code
//   valid     : some exception or interrupt is present
//   cause     : selected {intr, code}
//   tval_zero : mtval must be written as 0 (interrupt, ecall, breakpoint)
module priv_trap_prio_enc
    import priv_trap_pkg::*;
(
    input  logic [EXC_W-1:0] exc_flags,
    input  logic [INT_W-1:0] int_pend,
    input  logic [1:0]       curr_priv,
    output logic             valid,
    output trap_cause_t      cause,
    output logic             tval_zero
);

    always_comb begin
        valid      = 1'b1;
        cause      = '0;
        tval_zero  = 1'b0;
        // Synchronous exceptions always beat interrupts.
        if (exc_flags[EXC_BIT_BREAKPOINT]) begin
            cause.code = EXC_BREAKPOINT;
            tval_zero  = 1'b1;
        end else if (exc_flags[EXC_BIT_FAULT_INSN_PAGE]) begin
            cause.code = EXC_PAGE_INSN;
        end else if (exc_flags[EXC_BIT_FAULT_INSN]) begin
            cause.code = EXC_FAULT_INSN;
        end else if (exc_flags[EXC_BIT_ILLEGAL_INSN]) begin
            cause.code = EXC_ILLEGAL;
        end else if (exc_flags[EXC_BIT_MAL_INSN]) begin
            cause.code = EXC_MAL_INSN;
        end else if (exc_flags[EXC_BIT_ENV]) begin
            // ecall from U/S/M maps to 8/9/11
            cause.code = EXC_ECALL_U + CODE_W'(curr_priv);
            tval_zero  = 1'b1;
        end else if (exc_flags[EXC_BIT_MAL_S]) begin
            cause.code = EXC_MAL_STORE;
        end else if (exc_flags[EXC_BIT_MAL_L]) begin
            cause.code = EXC_MAL_LOAD;
        end else if (exc_flags[EXC_BIT_FAULT_STORE_PAGE]) begin
            cause.code = EXC_PAGE_STORE;
        end else if (exc_flags[EXC_BIT_FAULT_LOAD_PAGE]) begin
            cause.code = EXC_PAGE_LOAD;
        end else if (exc_flags[EXC_BIT_FAULT_S]) begin
            cause.code = EXC_FAULT_STORE;
        end else if (exc_flags[EXC_BIT_FAULT_L]) begin
            cause.code = EXC_FAULT_LOAD;
        end else if (int_pend[INT_BIT_EXT]) begin
            cause.intr = 1'b1;
            cause.code = INT_EXT;
            tval_zero  = 1'b1;
        end else if (int_pend[INT_BIT_SOFT]) begin
            cause.intr = 1'b1;
            cause.code = INT_SOFT;
            tval_zero  = 1'b1;
        end else if (int_pend[INT_BIT_TIMER]) begin
            cause.intr = 1'b1;
            cause.code = INT_TIMER;
            tval_zero  = 1'b1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer
// Sequences trap entry, xRET return and WFI sleep between the hazard unit
// and the CSR file.
//   CLK, RST      : clock, asynchronous active-high reset
//   exc_flags     : raw exception flags, int_pend : masked interrupts
//   mret/sret/wfi : commit strobes from the pipeline
//   ex_mem_stall  : memory stage busy, trap entry waits in DRAIN
//   pipe_clear    : hazard unit flush-complete acknowledge
//   epc_in, badaddr_in, curr_priv, mtvec, mepc, sepc : trap context
//   csr_trap_we / csr_ret_we : one-cycle CSR update strobes
//   mcause_o, mepc_o, mtval_o : latched trap context for the CSR file
//   insert_pc, priv_pc : redirect request and target
//   wfi_sleep     : pipeline hold while sleeping
//   state_dbg     : current FSM state
//
// Redirect handshake: insert_pc acts as valid and pipe_clear as ready. Once
// insert_pc rises, priv_pc is held stable until a cycle in which both are
// high; that cycle completes the transfer and insert_pc drops after it.
module priv_trap_sequencer
    import priv_trap_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int CAUSE_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [EXC_W-1:0]  exc_flags,
    input  logic              mret,
    input  logic              sret,
    input  logic              wfi,
    input  logic [INT_W-1:0]  int_pend,
    input  logic              ex_mem_stall,
    input  logic              pipe_clear,
    input  logic [WORD_W-1:0] epc_in,
    input  logic [WORD_W-1:0] badaddr_in,
    input  logic [1:0]        curr_priv,
    input  logic [WORD_W-1:0] mtvec,
    input  logic [WORD_W-1:0] mepc,
    input  logic [WORD_W-1:0] sepc,
    output logic              csr_trap_we,
    output logic              csr_ret_we,
    output logic [WORD_W-1:0] mcause_o,
    output logic [WORD_W-1:0] mepc_o,
    output logic [WORD_W-1:0] mtval_o,
    output logic              insert_pc,
    output logic [WORD_W-1:0] priv_pc,
    output logic              wfi_sleep,
    output trap_state_t       state_dbg
);

    trap_state_t      state;
    trap_cause_t      cause_q;
    logic [EXC_W-1:0] exc_gated;
    logic             enc_valid;
    logic             enc_tval_zero;
    trap_cause_t      enc_cause;
    logic [WORD_W-1:0] tval_next;

    // Exceptions cannot wake a sleeping hart; only interrupts reach the encoder there.
    assign exc_gated = (state == ST_SLEEP) ? '0 : exc_flags;
    assign tval_next = enc_tval_zero ? '0 : badaddr_in;
    assign state_dbg = state;

    priv_trap_prio_enc u_prio_enc (
        .exc_flags (exc_gated),
        .int_pend  (int_pend),
        .curr_priv (curr_priv),
        .valid     (enc_valid),
        .cause     (enc_cause),
        .tval_zero (enc_tval_zero)
    );

    function automatic logic [WORD_W-1:0] cause_word(input trap_cause_t c);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[WORD_W-1]    = c.intr;
        w[CAUSE_W-1:0] = CAUSE_W'(c.code);
        return w;
    endfunction

    // Only interrupts in vectored mode get an offset; everything else uses the base.
    function automatic logic [WORD_W-1:0] trap_target(input trap_cause_t c,
                                                      input logic [WORD_W-1:0] tvec);
        logic [WORD_W-1:0] base;
        base = {tvec[WORD_W-1:2], 2'b00};
        if (c.intr && (tvec[1:0] == 2'b01)) begin
            return base + (WORD_W'(c.code) << 2);
        end
        return base;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cause_q     <= '0;
            csr_trap_we <= 1'b0;
            csr_ret_we  <= 1'b0;
            mcause_o    <= '0;
            mepc_o      <= '0;
            mtval_o     <= '0;
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            wfi_sleep   <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the transition into UPDATE raises them.
            csr_trap_we <= 1'b0;
            csr_ret_we  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        cause_q  <= enc_cause;
                        mcause_o <= cause_word(enc_cause);
                        mepc_o   <= epc_in;
                        mtval_o  <= tval_next;
                        if (ex_mem_stall) begin
                            state <= ST_DRAIN;
                        end else begin
                            state       <= ST_UPDATE;
                            csr_trap_we <= 1'b1;
                            priv_pc     <= trap_target(enc_cause, mtvec);
                        end
                    end else if (mret || sret) begin
                        state      <= ST_UPDATE;
                        csr_ret_we <= 1'b1;
                        priv_pc    <= mret ? mepc : sepc;
                    end else if (wfi) begin
                        state     <= ST_SLEEP;
                        wfi_sleep <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!ex_mem_stall) begin
                        state       <= ST_UPDATE;
                        csr_trap_we <= 1'b1;
                        priv_pc     <= trap_target(cause_q, mtvec);
                    end
                end
                ST_UPDATE: begin
                    state     <= ST_REDIRECT;
                    insert_pc <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (pipe_clear) begin
                        state     <= ST_IDLE;
                        insert_pc <= 1'b0;
                    end
                end
                ST_SLEEP: begin
                    if (enc_valid) begin
                        cause_q     <= enc_cause;
                        mcause_o    <= cause_word(enc_cause);
                        mepc_o      <= epc_in;
                        mtval_o     <= tval_next;
                        wfi_sleep   <= 1'b0;
                        state       <= ST_UPDATE;
                        csr_trap_we <= 1'b1;
                        priv_pc     <= trap_target(enc_cause, mtvec);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
module tb_priv_trap_sequencer;
    import priv_trap_pkg::*;

    // exc_flags bit positions, MSB = breakpoint ... LSB = fault_l
    localparam int B_FL = 0, B_FS = 1, B_FLP = 2, B_FSP = 3, B_ML = 4, B_MS = 5;
    localparam int B_ENV = 6, B_MI = 7, B_ILL = 8, B_FI = 9, B_FIP = 10, B_BP = 11;
    localparam logic [2:0] I_TIM = 3'b001, I_SOFT = 3'b010, I_EXT = 3'b100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] exc_flags = '0;
    logic        mret = 0, sret = 0, wfi = 0;
    logic [2:0]  int_pend = '0;
    logic        ex_mem_stall = 0, pipe_clear = 0;
    logic [31:0] epc_in = '0, badaddr_in = '0, mtvec = '0, mepc = '0, sepc = '0;
    logic [1:0]  curr_priv = '0;
    logic        csr_trap_we, csr_ret_we, insert_pc, wfi_sleep;
    logic [31:0] mcause_o, mepc_o, mtval_o, priv_pc;
    trap_state_t state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    priv_trap_sequencer #(.WORD_W(32), .CAUSE_W(5)) dut (
        .CLK(CLK), .RST(RST), .exc_flags(exc_flags), .mret(mret), .sret(sret), .wfi(wfi),
        .int_pend(int_pend), .ex_mem_stall(ex_mem_stall), .pipe_clear(pipe_clear),
        .epc_in(epc_in), .badaddr_in(badaddr_in), .curr_priv(curr_priv), .mtvec(mtvec),
        .mepc(mepc), .sepc(sepc), .csr_trap_we(csr_trap_we), .csr_ret_we(csr_ret_we),
        .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o), .insert_pc(insert_pc),
        .priv_pc(priv_pc), .wfi_sleep(wfi_sleep), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [11:0] exc;
        logic [2:0]  intp;
        logic [1:0]  priv;
        logic [31:0] tvec;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [31:0] exp_cause;
        logic [31:0] exp_tval;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic clear_inputs();
        exc_flags = '0; int_pend = '0; mret = 0; sret = 0; wfi = 0;
    endtask

    // drive one trap from IDLE with no stall and walk it through UPDATE and REDIRECT
    task automatic run_vec(input vec_t v);
        exc_flags = v.exc; int_pend = v.intp; curr_priv = v.priv;
        mtvec = v.tvec; epc_in = v.epc; badaddr_in = v.bad; ex_mem_stall = 0;
        step();
        clear_inputs();
        check({v.name, ".trap_we"}, 32'(csr_trap_we), 32'd1);
        check({v.name, ".mcause"}, mcause_o, v.exp_cause);
        check({v.name, ".mepc"}, mepc_o, v.epc);
        check({v.name, ".mtval"}, mtval_o, v.exp_tval);
        check({v.name, ".insert_n1"}, 32'(insert_pc), 32'd0);
        step();
        check({v.name, ".insert_n2"}, 32'(insert_pc), 32'd1);
        check({v.name, ".trap_we_n2"}, 32'(csr_trap_we), 32'd0);
        check({v.name, ".priv_pc"}, priv_pc, v.exp_pc);
        pipe_clear = 1;
        step();
        pipe_clear = 0;
        check({v.name, ".insert_done"}, 32'(insert_pc), 32'd0);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{"illegal",   12'(1) << B_ILL, 3'b0, 2'd3, 32'h8000, 32'h100, 32'hDEAD, 32'd2, 32'hDEAD, 32'h8000};
        vecs[1]  = '{"timer_vec", 12'h0, I_TIM, 2'd3, 32'h8001, 32'h204, 32'hBEEF, 32'h80000007, 32'h0, 32'h801C};
        vecs[2]  = '{"ecall_u",   12'(1) << B_ENV, 3'b0, 2'd0, 32'h8000, 32'h300, 32'h1234, 32'd8, 32'h0, 32'h8000};
        vecs[3]  = '{"ecall_m",   12'(1) << B_ENV, 3'b0, 2'd3, 32'h8000, 32'h304, 32'h1234, 32'd11, 32'h0, 32'h8000};
        vecs[4]  = '{"ecall_s",   12'(1) << B_ENV, 3'b0, 2'd1, 32'h8000, 32'h308, 32'h1234, 32'd9, 32'h0, 32'h8000};
        vecs[5]  = '{"bp_wins",   (12'(1) << B_BP) | (12'(1) << B_ILL), I_EXT, 2'd3, 32'h8001, 32'h30C, 32'h55, 32'd3, 32'h0, 32'h8000};
        vecs[6]  = '{"spf_fl",    (12'(1) << B_FSP) | (12'(1) << B_FL), 3'b0, 2'd3, 32'h9000, 32'h310, 32'hA0, 32'd15, 32'hA0, 32'h9000};
        vecs[7]  = '{"ext_vec",   12'h0, I_EXT | I_SOFT | I_TIM, 2'd3, 32'h8001, 32'h314, 32'h77, 32'h8000000B, 32'h0, 32'h802C};
        vecs[8]  = '{"soft_vec",  12'h0, I_SOFT | I_TIM, 2'd3, 32'h1001, 32'h318, 32'h77, 32'h80000003, 32'h0, 32'h100C};
        vecs[9]  = '{"mal_insn",  (12'(1) << B_MI) | (12'(1) << B_ENV), 3'b0, 2'd3, 32'h8000, 32'h31C, 32'h31E, 32'd0, 32'h31E, 32'h8000};
        vecs[10] = '{"fs_fl",     (12'(1) << B_FS) | (12'(1) << B_FL), 3'b0, 2'd3, 32'h8000, 32'h320, 32'hC4, 32'd7, 32'hC4, 32'h8000};
        vecs[11] = '{"lpf_fs",    (12'(1) << B_FLP) | (12'(1) << B_FS) | (12'(1) << B_MS), 3'b0, 2'd3, 32'h8000, 32'h324, 32'hC8, 32'd6, 32'hC8, 32'h8000};
        vecs[12] = '{"fi_ill",    (12'(1) << B_FI) | (12'(1) << B_ILL) | (12'(1) << B_FIP), 3'b0, 2'd3, 32'h8001, 32'h328, 32'h328, 32'd12, 32'h328, 32'h8000};
        vecs[13] = '{"ext_mode2", 12'h0, I_EXT, 2'd3, 32'h8002, 32'h32C, 32'h9, 32'h8000000B, 32'h0, 32'h8000};

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst.state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst.outputs", {26'b0, csr_trap_we, csr_ret_we, insert_pc, wfi_sleep, 2'b0}, 32'd0);
        check("rst.mcause", mcause_o, 32'd0);
        check("rst.priv_pc", priv_pc, 32'd0);
        RST = 0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // DRAIN: load misaligned beats fault_l and ext; stall high for 3 cycles
        exc_flags = (12'(1) << B_FL) | (12'(1) << B_ML); int_pend = I_EXT;
        epc_in = 32'h500; badaddr_in = 32'h1003; mtvec = 32'h8000; ex_mem_stall = 1;
        step();
        clear_inputs();
        exc_flags = 12'(1) << B_ILL;  // must be ignored while draining
        cnt = 0;
        for (int t = 0; t < 20 && state_dbg == ST_DRAIN; t++) begin
            if (cnt >= 2) ex_mem_stall = 0;
            check("drain.no_we", 32'(csr_trap_we), 32'd0);
            cnt++;
            step();
        end
        clear_inputs();
        ex_mem_stall = 0;
        check("drain.cycles", 32'(cnt), 32'd3);
        check("drain.trap_we", 32'(csr_trap_we), 32'd1);
        check("drain.mcause", mcause_o, 32'd4);
        check("drain.mtval", mtval_o, 32'h1003);
        check("drain.mepc", mepc_o, 32'h500);
        step();
        pipe_clear = 1;
        step();
        pipe_clear = 0;

        // WFI then timer after 5 sleep cycles; exception flags ignored in sleep
        wfi = 1; mtvec = 32'h8001;
        step();
        wfi = 0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            exc_flags = 12'(1) << B_ILL;
            if (i == 4) int_pend = I_TIM;
            if (wfi_sleep) cnt++;
            check("wfi.no_we", 32'(csr_trap_we), 32'd0);
            step();
        end
        clear_inputs();
        check("wfi.sleep_cycles", 32'(cnt), 32'd5);
        check("wfi.sleep_off", 32'(wfi_sleep), 32'd0);
        check("wfi.trap_we", 32'(csr_trap_we), 32'd1);
        check("wfi.mcause", mcause_o, 32'h80000007);
        check("wfi.mtval", mtval_o, 32'd0);
        check("wfi.priv_pc", priv_pc, 32'h801C);
        step();
        pipe_clear = 1;
        step();
        pipe_clear = 0;

        // exception beats mret
        exc_flags = 12'(1) << B_ILL; mret = 1; mepc = 32'h400; mtvec = 32'h8000; badaddr_in = 32'h11;
        step();
        clear_inputs();
        check("exc_vs_mret.trap_we", 32'(csr_trap_we), 32'd1);
        check("exc_vs_mret.ret_we", 32'(csr_ret_we), 32'd0);
        step();
        pipe_clear = 1;
        step();
        pipe_clear = 0;

        // mret (beats sret and wfi), pipe_clear delayed so insert_pc lasts 4 cycles
        mret = 1; sret = 1; wfi = 1; mepc = 32'h400; sepc = 32'h600;
        step();
        clear_inputs();
        check("mret.ret_we", 32'(csr_ret_we), 32'd1);
        check("mret.trap_we", 32'(csr_trap_we), 32'd0);
        check("mret.priv_pc", priv_pc, 32'h400);
        step();
        check("mret.ret_we_off", 32'(csr_ret_we), 32'd0);
        cnt = 0;
        for (int t = 0; t < 20 && insert_pc; t++) begin
            pipe_clear = (cnt == 3);
            check("mret.pc_stable", priv_pc, 32'h400);
            cnt++;
            step();
        end
        pipe_clear = 0;
        check("mret.insert_cycles", 32'(cnt), 32'd4);
        check("mret.state_idle", 32'(state_dbg), 32'(ST_IDLE));

        // sret with pipe_clear already high: REDIRECT lasts one cycle
        sret = 1; pipe_clear = 1;
        step();
        clear_inputs();
        check("sret.ret_we", 32'(csr_ret_we), 32'd1);
        check("sret.priv_pc", priv_pc, 32'h600);
        step();
        cnt = 0;
        for (int t = 0; t < 20 && insert_pc; t++) begin
            cnt++;
            step();
        end
        pipe_clear = 0;
        check("sret.insert_cycles", 32'(cnt), 32'd1);

        // reset in the middle of REDIRECT
        sret = 1;
        step();
        clear_inputs();
        step();
        check("rstmid.insert_before", 32'(insert_pc), 32'd1);
        #2 RST = 1;
        #1;
        check("rstmid.insert", 32'(insert_pc), 32'd0);
        check("rstmid.priv_pc", priv_pc, 32'd0);
        check("rstmid.mcause", mcause_o, 32'd0);
        check("rstmid.state", 32'(state_dbg), 32'(ST_IDLE));
        #1 RST = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid.no_strobe", {30'b0, csr_trap_we, csr_ret_we}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
